// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch_stage and decode, with redirect flush.
// Optional INSTR_QUEUE_BYPASS_EN: zero-latency pass-through when empty.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int ILEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [ILEN-1:0]          instruction_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [ILEN-1:0]          instruction_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ILEN-1:0] mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [ILEN-1:0] head_data;

  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0])
              && (head[AW] != tail[AW]);

  assign head_data     = mem[head[AW-1:0]];
  assign issue_ready_o = !full;
  assign count_o       = tail - head;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // Empty queue hands the fetched word straight to decode.
  assign bypass      = empty && issue_valid_i && !flush_i;
  assign bypass_take = bypass && instr_ready_i;

  assign push = issue_valid_i && issue_ready_o
             && !flush_i && !bypass_take;
  assign pop  = !empty && instr_ready_i && !flush_i;

  always_comb begin
    instr_valid_o = !empty || bypass;
    instruction_o = '0;
    if (!empty)
      instruction_o = head_data;
    else if (bypass)
      instruction_o = instruction_i;
  end
`else
  assign push = issue_valid_i && issue_ready_o && !flush_i;
  assign pop  = instr_valid_o && instr_ready_i && !flush_i;

  always_comb begin
    instr_valid_o = !empty;
    instruction_o = '0;
    if (!empty)
      instruction_o = head_data;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head <= '0;
      tail <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[tail[AW-1:0]] <= instruction_i;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed steps with a
// queue scoreboard and a behavioural occupancy model.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int ILEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [ILEN-1:0] instr_in = '0;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [ILEN-1:0] instr_out;
  logic [$clog2(DEPTH):0] count;

  instr_queue #(
    .DEPTH(DEPTH),
    .ILEN (ILEN)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .issue_valid_i(issue_valid),
    .issue_ready_o(issue_ready),
    .instruction_i(instr_in),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instruction_o(instr_out),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m_cnt     = 0;
  logic [ILEN-1:0] exp_q[$];

`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One clock of stimulus; checks outputs before and after the edge.
  task automatic cycle(input bit v, input logic [31:0] d,
                       input bit r, input bit f);
    bit byp, acc, pp;
    logic [31:0] exp_o;
    issue_valid = v;
    instr_in    = d;
    instr_ready = r;
    flush       = f;
    #1;
    byp = BYP && (m_cnt == 0) && v && !f;
    exp_o = (m_cnt != 0) ? exp_q[0] : (byp ? d : 32'h0);
    check("valid", 32'(instr_valid), 32'((m_cnt != 0) || byp));
    check("data", instr_out, exp_o);
    check("ready", 32'(issue_ready), 32'(m_cnt != DEPTH));
    pp  = (m_cnt != 0) && r && !f;
    acc = v && (m_cnt != DEPTH) && !f && !(byp && r);
    if (f) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (pp) begin
        void'(exp_q.pop_front());
        m_cnt--;
      end
      if (acc) begin
        exp_q.push_back(d);
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_data", instr_out, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single push, visible next cycle
    cycle(1, 32'h0000_0013, 0, 0);
    cycle(0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 0, 0);

    // fill, refused extra push, drain
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 32'hA000_0000 + i, 0, 0);
    cycle(1, 32'hA000_0099, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 0, 0);

    // streaming through pointer wrap
    for (int i = 0; i < 20; i++)
      cycle(1, 32'hB000_0000 + i, 1, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 0, 0);

    // flush discards same-cycle push and pop
    for (int i = 0; i < 5; i++)
      cycle(1, 32'hC000_0000 + i, 0, 0);
    cycle(1, 32'hC000_00FF, 1, 1);
    cycle(0, 32'h0, 0, 0);

    // full: pop-only, push accepted the cycle after
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 32'hD000_0000 + i, 0, 0);
    cycle(1, 32'hD000_0080, 1, 0);
    cycle(1, 32'hD000_0081, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 0, 0);

    // empty-queue pass-through case
    cycle(1, 32'hDEAD_BEEF, 1, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(1, 32'hDEAD_BEEF, 0, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 0, 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++)
      cycle(1, 32'hE000_0000 + i, 0, 0);
    issue_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_ready", 32'(issue_ready), 32'd1);
    check("arst_data", instr_out, 32'h0);
    check("arst_count", 32'(count), 32'd0);
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 32'hF000_0001, 0, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Instruction queue between fetch_stage (upstream) and the decode stage (downstream).
- Buffers fetched instructions in a circular FIFO so fetch stalls and decode stalls are decoupled.
- Accepts instructions on the fetch issue handshake and presents them in order on a valid/ready handshake to decode.
- Supports a single-cycle flush on pipeline redirect (exception or mispredict).

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ILEN, 32, instruction width in bits (matches mmm_pkg ILEN).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush; empties the queue
- issue_valid_i  in  1  fetch_stage has an instruction
- issue_ready_o  out  1  queue can accept an instruction
- instruction_i  in  ILEN  instruction from fetch_stage
- instr_valid_o  out  1  head instruction is valid for decode
- instr_ready_i  in  1  decode consumes the head
- instruction_o  out  ILEN  head instruction
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n_i low):
  - head and tail pointers = 0; count = 0.
  - instr_valid_o = 0, issue_ready_o = 1, instruction_o = 0, count_o = 0.
  - Storage array is not reset.
- Pointers:
  - log2(DEPTH)+1 bits each; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Push:
  - Occurs when issue_valid_i && issue_ready_o && !flush_i.
  - Writes mem[tail] and increments tail.
- Pop:
  - Occurs when instr_valid_o && instr_ready_i && !flush_i.
  - Increments head.
- issue_ready_o = !full. It is registered-state-only; there is no combinational path from instr_ready_i.
- When full, a push is refused even if a pop happens in the same cycle. The slot becomes available the following cycle.
- Push and pop in the same cycle (not full, not empty): count unchanged; both pointers advance.
- Latency: an instruction pushed in cycle N appears on instruction_o with instr_valid_o=1 in cycle N+1.
- Output drive:
  - instr_valid_o = !empty.
  - instruction_o = mem[head] when not empty, 0 when empty.
- Flush:
  - On a clock edge with flush_i=1: head = tail = 0 and count = 0.
  - Any push or pop in that cycle is discarded.
  - Flush has priority over push and pop.
  - In the cycle after a flush: instr_valid_o = 0, issue_ready_o = 1.
- count_o = tail − head (full pointer width). Range is 0..DEPTH.
- Ordering: strict FIFO; no reordering or duplication.
- Reset asserted mid-operation: all contents are lost immediately and outputs take their reset values asynchronously.

Optional Feature:
- Macro: INSTR_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty and issue_valid_i=1 and flush_i=0:
    - instr_valid_o = 1 and instruction_o = instruction_i combinationally.
  - If instr_ready_i=1 in that cycle, the instruction is consumed directly: nothing is written and the pointers are unchanged.
  - If instr_ready_i=0, it is written as a normal push.
  - Zero-cycle latency when empty. A combinational path from issue_valid_i/instruction_i to the outputs is allowed.
- Not defined:
  - Pure registered FIFO with the 1-cycle minimum latency above.
  - No combinational input-to-output path.

Test Plan:
1. Reset, then push 0x00000013 with instr_ready_i=0:
   - instr_valid_o=1 and instruction_o=0x00000013 the next cycle; count_o=1.
2. Push 8 instructions A0..A7 with instr_ready_i=0 (DEPTH=8):
   - issue_ready_o=0 after the 8th push; count_o=8.
   - A 9th issue_valid_i is not accepted.
   - Then drain with instr_ready_i=1: A0..A7 come out in order, one per cycle; count_o returns to 0 and issue_ready_o=1.
3. Continuous stream of 20 instructions with issue_valid_i=1 and instr_ready_i=1 every cycle:
   - Output sequence matches input, shifted by 1 cycle; count_o stays at 1.
   - Pointers wrap past index 7 without loss.
4. With 5 entries queued, assert flush_i for 1 cycle while issue_valid_i=1 and instr_ready_i=1:
   - Next cycle: count_o=0, instr_valid_o=0, issue_ready_o=1.
   - Neither the flushed-cycle push nor the flushed-cycle pop takes effect.
5. Full queue with instr_ready_i=1 and issue_valid_i=1 in the same cycle:
   - Pop only; count_o=7 next cycle.
   - The push is accepted in the following cycle (count_o=8).
6. With INSTR_QUEUE_BYPASS_EN defined, empty queue, issue_valid_i=1 with 0xDEADBEEF and instr_ready_i=1:
   - Same cycle: instr_valid_o=1 and instruction_o=0xDEADBEEF.
   - count_o stays 0.
   - Repeat with instr_ready_i=0: count_o=1 next cycle.
